// File: rtl/regfile_pkg.sv
// regfile_pkg: definitions shared by the register file and the decode stage.
//   state_t   - clearing sequencer states (CLEAR zeroes the array, RUN is normal use)
//   ZERO_WORD - all-zero word for the 32-bit core datapath
//   RD_EN / WR_EN - active levels of the per-port read and write enables
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic RD_EN = 1'b1;
  localparam logic WR_EN = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
// It selects between the zero value, same-cycle write data (bypass) and the
// stored array word, and flags reads whose source still has a producer in flight.
//   rst, ready   - file state; rdata is forced to zero unless ready and not in reset
//   re, raddr    - this port's read enable and address
//   arr_data     - array word at raddr
//   pending      - scoreboard bit at raddr
//   we/waddr/wdata - all write ports, packed, used for the bypass
//   rdata, rbusy - read result and outstanding-producer flag
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic                     pending,
  input  logic [NWR-1:0]           we,
  input  logic [NWR*ADDR_W-1:0]    waddr,
  input  logic [NWR*DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic              hit;
  logic [DATA_W-1:0] byp;

  // Ascending scan: the highest-index matching write port is the one that
  // lands in the array, so it is also the one forwarded.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] == WR_EN && waddr[i*ADDR_W +: ADDR_W] == raddr) begin
        hit = 1'b1;
        byp = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (rst || !ready || re != RD_EN)
      rdata = '0;
    else if (ZERO_REG && raddr == '0)
      rdata = '0;
    else if (hit)
      rdata = byp;
    else
      rdata = arr_data;
  end

  // A write in this cycle satisfies the read through the bypass.
  assign rbusy = ready & re & pending & ~hit;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read
// bypass, pending-write scoreboard and a post-reset clearing sequencer.
//   clk, rst            - clock, synchronous active-high reset
//   we, waddr, wdata    - NWR write ports, packed [i*W +: W]
//   re, raddr, rdata    - NRD combinational read ports, packed
//   rbusy               - per read port: source register has an outstanding producer
//   sb_set, sb_addr     - mark a register pending when a multi-cycle producer issues
//   ready               - clearing finished, file usable
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr,
  output logic                  ready
);

  localparam int NREG = 1 << ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NREG - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;

  // Clearing sequencer: one register per cycle, RUN after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_CNT) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: ;
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Array: no reset of its own; the sequencer zeroes it. Writes arriving
  // with rst or during CLEAR are dropped. Ascending loop lets the
  // highest-index port win an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[cnt[ADDR_W-1:0]] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (we[i] == WR_EN && !(ZR && waddr[i*ADDR_W +: ADDR_W] == '0))
            regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard: clears first, set last, so a newly issued producer wins
  // over a completing write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] == WR_EN)
          pending[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (sb_set && !(ZR && sb_addr == '0))
        pending[sb_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NWR      (NWR),
      .ZERO_REG (ZR)
    ) u_rd (
      .rst      (rst),
      .ready    (ready),
      .re       (re[k]),
      .raddr    (ra),
      .arr_data (regs[ra]),
      .pending  (pending[ra]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[k*DATA_W +: DATA_W]),
      .rbusy    (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic                  ready;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  // Count cycles with ready low after rst has been released, bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 64) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    rst = 1'b1; re = '0; raddr = '0;
    idle();
    tick();
    rst = 1'b0;
    // right after the reset edge
    re = 2'b11; raddr = {5'd3, 5'd1};
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rbusy", 32'(rbusy), 32'd0);
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rdata1", rdata[63:32], 32'h0);

    // writes during CLEAR must be ignored
    we = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'hDEAD_BEEF};
    sb_set = 1'b1; sb_addr = 5'd10;
    wait_ready("clear_len");
    idle();
    raddr = {5'd31, 5'd10};
    #1;
    chk("clear_ready", 32'(ready), 32'd1);
    chk("clear_we_ign", rdata[31:0], 32'h0);
    chk("clear_sb_ign", 32'(rbusy), 32'd0);
    chk("clear_r31", rdata[63:32], 32'h0);

    // bypass: both ports write 5, highest index wins
    we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h0000_BBBB, 32'h0000_AAAA};
    re = 2'b01; raddr = {5'd0, 5'd5};
    #1;
    chk("byp_same", rdata[31:0], 32'h0000_BBBB);
    tick();
    idle();
    #1;
    chk("byp_array", rdata[31:0], 32'h0000_BBBB);

    // independent writes on both ports, read on both ports
    we = 2'b11; waddr = {5'd13, 5'd12}; wdata = {32'h2222_2222, 32'h1111_1111};
    tick();
    idle();
    re = 2'b11; raddr = {5'd13, 5'd12};
    #1;
    chk("wr_p0", rdata[31:0], 32'h1111_1111);
    chk("wr_p1", rdata[63:32], 32'h2222_2222);
    re = 2'b10;
    #1;
    chk("re_off", rdata[31:0], 32'h0);

    // zero register
    re = 2'b01; raddr = {5'd0, 5'd0};
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF_FFFF};
    sb_set = 1'b1; sb_addr = 5'd0;
    #1;
    chk("zero_same", rdata[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("zero_rdata", rdata[31:0], 32'h0);
    chk("zero_rbusy", 32'(rbusy[0]), 32'd0);

    // scoreboard set, then satisfied by a write
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    idle();
    re = 2'b10; raddr = {5'd7, 5'd0};
    #1;
    chk("sb_busy", 32'(rbusy[1]), 32'd1);
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h0000_1234};
    #1;
    chk("sb_wr_busy", 32'(rbusy[1]), 32'd0);
    chk("sb_wr_data", rdata[63:32], 32'h0000_1234);
    tick();
    idle();
    #1;
    chk("sb_cleared", 32'(rbusy[1]), 32'd0);
    chk("sb_data", rdata[63:32], 32'h0000_1234);

    // set and clear on the same edge: set wins
    sb_set = 1'b1; sb_addr = 5'd9;
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h0000_5678};
    tick();
    idle();
    re = 2'b10; raddr = {5'd9, 5'd0};
    #1;
    chk("coll_busy", 32'(rbusy[1]), 32'd1);
    chk("coll_data", rdata[63:32], 32'h0000_5678);

    // fill 1..31, mark 3 pending, reset mid-RUN
    for (int a = 1; a < 32; a++) begin
      we = 2'b01; waddr = {5'd0, 5'(a)}; wdata = {32'h0, 32'h100 + 32'(a)};
      tick();
    end
    idle();
    sb_set = 1'b1; sb_addr = 5'd3;
    tick();
    idle();
    re = 2'b11; raddr = {5'd31, 5'd3};
    #1;
    chk("fill_r31", rdata[63:32], 32'h0000_011F);
    chk("fill_busy3", 32'(rbusy[0]), 32'd1);
    chk("fill_r3", rdata[31:0], 32'h0000_0103);

    rst = 1'b1;
    #1;
    chk("rst_in_rdata", rdata[63:32], 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_rbusy", 32'(rbusy), 32'd0);
    chk("rst2_ready", 32'(ready), 32'd0);
    wait_ready("clear2_len");
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("clr_r%0d", a), rdata[31:0], 32'h0);
    end
    raddr = {5'd3, 5'd3};
    #1;
    chk("clr_busy3", 32'(rbusy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
